// File: rtl/rv32_hart_scheduler.sv
// Round-robin issue scheduler for the barrel core: picks one eligible hart per cycle and registers it into decode.
// Optional per-hart issue / idle counters are enabled with HART_SCHED_PERF_EN.
module rv32_hart_scheduler #(
    parameter int unsigned NUM_HARTS = 8,
    parameter int unsigned HART_ID_W = $clog2(NUM_HARTS),
    parameter int unsigned XPR_LEN   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_HARTS-1:0]         fetch_valid,
    input  logic [NUM_HARTS*XPR_LEN-1:0] fetch_instr,
    output logic [NUM_HARTS-1:0]         fetch_ready,
    input  logic [NUM_HARTS-1:0]         stall_req,
    output logic [XPR_LEN-1:0]           dec_instr,
    output logic                         dec_valid,
    output logic [HART_ID_W-1:0]         dec_hart_id,
    input  logic                         dec_trap,
    input  logic [NUM_HARTS-1:0]         trap_clear,
    output logic [NUM_HARTS-1:0]         hart_trapped,
    output logic                         trap_valid,
    output logic [HART_ID_W-1:0]         trap_hart_id
`ifdef HART_SCHED_PERF_EN
    ,
    output logic [NUM_HARTS*32-1:0]      perf_issue_cnt,
    output logic [31:0]                  perf_idle_cnt
`endif
);

    localparam logic [XPR_LEN-1:0] NOP = XPR_LEN'(32'h0000_0013);

    typedef enum logic {RUN, TRAPPED} hart_state_e;

    hart_state_e                 state      [NUM_HARTS];
    hart_state_e                 state_next [NUM_HARTS];
    logic        [NUM_HARTS-1:0] elig;
    logic                        grant;
    logic        [HART_ID_W-1:0] winner;
    logic        [HART_ID_W-1:0] last_grant;
    int unsigned                 scan_idx;

    always_ff @(posedge clk) begin
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            if (rst) state[h] <= RUN;
            else     state[h] <= state_next[h];
        end
    end

    // A trap on the hart in decode beats a clear arriving in the same cycle.
    always_comb begin
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            state_next[h] = state[h];
            if (dec_valid && dec_trap && dec_hart_id == HART_ID_W'(h))
                state_next[h] = TRAPPED;
            else if (trap_clear[h])
                state_next[h] = RUN;
        end
    end

    always_comb begin
        hart_trapped = '0;
        elig         = '0;
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            hart_trapped[h] = (state[h] == TRAPPED);
            elig[h] = fetch_valid[h] & ~stall_req[h] & (state[h] == RUN)
                    & ~(dec_valid && dec_hart_id == HART_ID_W'(h));
        end
    end

    // Scan starts one past the last winner and wraps, so the last winner has lowest priority.
    always_comb begin
        grant       = 1'b0;
        winner      = '0;
        scan_idx    = 0;
        fetch_ready = '0;
        for (int unsigned k = 1; k <= NUM_HARTS; k++) begin
            scan_idx = (32'(last_grant) + k) % NUM_HARTS;
            if (!grant && elig[scan_idx]) begin
                grant  = 1'b1;
                winner = HART_ID_W'(scan_idx);
            end
        end
        if (rst) grant = 1'b0;
        if (grant) fetch_ready[winner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_valid    <= 1'b0;
            dec_instr    <= NOP;
            dec_hart_id  <= '0;
            trap_valid   <= 1'b0;
            trap_hart_id <= '0;
            last_grant   <= HART_ID_W'(NUM_HARTS - 1);
        end else begin
            if (grant) begin
                dec_valid   <= 1'b1;
                dec_instr   <= fetch_instr[winner*XPR_LEN +: XPR_LEN];
                dec_hart_id <= winner;
                last_grant  <= winner;
            end else begin
                dec_valid <= 1'b0;
                dec_instr <= NOP;
            end
            trap_valid <= dec_valid && dec_trap;
            if (dec_valid && dec_trap) trap_hart_id <= dec_hart_id;
        end
    end

`ifdef HART_SCHED_PERF_EN
    logic [31:0] issue_cnt [NUM_HARTS];
    logic [31:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned h = 0; h < NUM_HARTS; h++) issue_cnt[h] <= '0;
            idle_cnt <= '0;
        end else if (grant) begin
            issue_cnt[winner] <= issue_cnt[winner] + 32'd1;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

    always_comb begin
        perf_issue_cnt = '0;
        for (int unsigned h = 0; h < NUM_HARTS; h++)
            perf_issue_cnt[h*32 +: 32] = issue_cnt[h];
    end

    assign perf_idle_cnt = idle_cnt;
`endif

endmodule

// File: tb/tb_rv32_hart_scheduler.sv
// Self-checking bench for rv32_hart_scheduler: directed and random stimulus against a behavioural model.
module tb_rv32_hart_scheduler;

    localparam int N = 8;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] TRAP = 32'hFFFF_FFFF;

    logic           clk;
    logic           rst;
    logic [N-1:0]   fv;
    logic [N*32-1:0] fi;
    logic [N-1:0]   fetch_ready;
    logic [N-1:0]   stall;
    logic [31:0]    dec_instr;
    logic           dec_valid;
    logic [2:0]     dec_hart_id;
    logic           dec_trap;
    logic           inj;
    logic [N-1:0]   clr;
    logic [N-1:0]   hart_trapped;
    logic           trap_valid;
    logic [2:0]     trap_hart_id;
`ifdef HART_SCHED_PERF_EN
    logic [N*32-1:0] perf_issue_cnt;
    logic [31:0]     perf_idle_cnt;
`endif

    // Decoder stand-in: all-ones word is illegal; inj forces a trap flag (ignored when not valid).
    assign dec_trap = (dec_instr == TRAP) | inj;

    rv32_hart_scheduler #(.NUM_HARTS(N), .XPR_LEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_valid  (fv),
        .fetch_instr  (fi),
        .fetch_ready  (fetch_ready),
        .stall_req    (stall),
        .dec_instr    (dec_instr),
        .dec_valid    (dec_valid),
        .dec_hart_id  (dec_hart_id),
        .dec_trap     (dec_trap),
        .trap_clear   (clr),
        .hart_trapped (hart_trapped),
        .trap_valid   (trap_valid),
        .trap_hart_id (trap_hart_id)
`ifdef HART_SCHED_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_idle_cnt  (perf_idle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int failed   = 0;

    // Reference model state
    logic [N-1:0] m_trapped;
    int           m_last;
    bit           m_dv;
    logic [31:0]  m_di;
    int           m_dh;
    bit           m_tv;
    int           m_th;
    int           m_issue [N];
    int           m_idle;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_trapped = '0;
        m_last    = N - 1;
        m_dv      = 0;
        m_di      = NOP;
        m_dh      = 0;
        m_tv      = 0;
        m_th      = 0;
        m_idle    = 0;
        for (int h = 0; h < N; h++) m_issue[h] = 0;
    endtask

    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
            int h;
            h = (m_last + k) % N;
            if (fv[h] && !stall[h] && !m_trapped[h] && !(m_dv && m_dh == h)) return h;
        end
        return -1;
    endfunction

    task automatic tick();
        int          w;
        logic [31:0] exp_fr;
        bit          tr;
        #1;
        w = rst ? -1 : pick();
        exp_fr = (w < 0) ? 32'h0 : (32'h1 << w);
        check("fetch_ready", 32'(fetch_ready), exp_fr);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            tr = m_dv && (m_di == TRAP || inj);
            for (int h = 0; h < N; h++) begin
                if (tr && m_dh == h) m_trapped[h] = 1'b1;
                else if (clr[h])     m_trapped[h] = 1'b0;
            end
            m_tv = tr;
            if (tr) m_th = m_dh;
            if (w >= 0) begin
                m_dv = 1; m_di = fi[w*32 +: 32]; m_dh = w; m_last = w;
                m_issue[w] = m_issue[w] + 1;
            end else begin
                m_dv = 0; m_di = NOP;
                m_idle = m_idle + 1;
            end
        end
        #1;
        check("dec_valid",    32'(dec_valid),    32'(m_dv));
        check("dec_instr",    dec_instr,         m_di);
        check("dec_hart_id",  32'(dec_hart_id),  32'(m_dh));
        check("hart_trapped", 32'(hart_trapped), 32'(m_trapped));
        check("trap_valid",   32'(trap_valid),   32'(m_tv));
        check("trap_hart_id", 32'(trap_hart_id), 32'(m_th));
        @(negedge clk);
    endtask

    task automatic rand_instrs();
        for (int h = 0; h < N; h++) fi[h*32 +: 32] = $urandom & 32'h7FFF_FFFF;
    endtask

    initial begin
        bit found;
        model_reset();
        rst = 1; fv = '0; stall = '0; clr = '0; inj = 0; fi = '0;
        @(negedge clk);
        tick(); tick();

        // All harts valid: strict rotation from hart 0
        rst = 0; fv = 8'hFF; rand_instrs();
        for (int i = 0; i < 10; i++) begin
            tick();
            rand_instrs();
        end

        // Lone hart 2 issues on alternate cycles
        fv = 8'h04;
        for (int i = 0; i < 6; i++) tick();

        // Hart 3 traps and is then never granted
        fv = 8'hFF; rand_instrs(); fi[3*32 +: 32] = TRAP;
        for (int i = 0; i < 14; i++) tick();
        check("trapped_after_trap", 32'(hart_trapped), 32'h08);

        // Release hart 3, then collide its next trap with a clear
        clr = 8'h08; tick(); clr = '0;
        for (int i = 0; i < 12; i++) begin
            clr = (m_dv && m_dh == 3 && m_di == TRAP) ? 8'h08 : 8'h00;
            tick();
        end
        clr = '0;
        check("trap_beats_clear", 32'(hart_trapped[3]), 32'h1);
        fi[3*32 +: 32] = 32'h0000_0033;
        clr = 8'h08; tick(); clr = '0;
        for (int i = 0; i < N; i++) tick();

        // Stall lower half, then release
        stall = 8'h0F;
        for (int i = 0; i < 10; i++) tick();
        stall = '0;
        for (int i = 0; i < 6; i++) tick();

        // Random phase
        for (int i = 0; i < 300; i++) begin
            fv    = 8'($urandom);
            stall = 8'($urandom & $urandom);
            clr   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            inj   = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            for (int h = 0; h < N; h++)
                fi[h*32 +: 32] = ($urandom_range(0, 7) == 0) ? TRAP : ($urandom & 32'h7FFF_FFFF);
            tick();
        end

        // Reset while a trapping instruction sits in decode
        rst = 0; fv = 8'hFF; stall = '0; clr = '0; inj = 0;
        for (int h = 0; h < N; h++) fi[h*32 +: 32] = TRAP;
        clr = 8'hFF; tick(); clr = '0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = m_dv && m_di == TRAP;
        end
        check("trap_in_decode_found", 32'(found), 32'h1);
        rst = 1; tick();
        check("reset_drops_trap", 32'(trap_valid), 32'h0);
        rst = 0; rand_instrs();
        tick();
        check("first_after_reset", 32'(dec_hart_id), 32'h0);
        for (int i = 0; i < 4; i++) tick();

        // Lone hart 0 for 100 cycles after reset
        rst = 1; tick(); rst = 0;
        fv = 8'h01;
        for (int i = 0; i < 100; i++) tick();
`ifdef HART_SCHED_PERF_EN
        check("perf_issue0_100", perf_issue_cnt[31:0], 32'd50);
        check("perf_idle_100",   perf_idle_cnt,        32'd50);
        for (int h = 0; h < N; h++)
            check("perf_issue_model", perf_issue_cnt[h*32 +: 32], 32'(m_issue[h]));
        check("perf_idle_model", perf_idle_cnt, 32'(m_idle));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/rv32_hart_scheduler.md
Name: rv32_hart_scheduler

Overview:
- Round-robin issue scheduler for the barrel core.
- Each cycle it picks one eligible hart's fetched instruction and registers it into the decode stage, driving the `rv32_decoder` instr input.
- Tracks the per-hart RUN/TRAPPED state from the decoder's `instr_trap`.
- Guarantees no hart has two instructions in decode at once and that nothing issues after a trapping instruction.

Parameters:
- NUM_HARTS, 8, number of hardware threads (2..16).
- HART_ID_W, $clog2(NUM_HARTS), width of hart index.
- XPR_LEN, 32 (from `XPR_LEN), instruction width.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- fetch_valid  in  NUM_HARTS  bit h: hart h has an instruction ready.
- fetch_instr  in  NUM_HARTS*XPR_LEN  hart h instruction at [h*XPR_LEN +: XPR_LEN].
- fetch_ready  out  NUM_HARTS  one-hot grant/pop, combinational, same cycle as selection.
- stall_req  in  NUM_HARTS  bit h: hart h must not issue this cycle (e.g. load pending).
- dec_instr  out  XPR_LEN  registered instruction to decoder.
- dec_valid  out  1  dec_instr holds a live instruction.
- dec_hart_id  out  HART_ID_W  owner of dec_instr.
- dec_trap  in  1  decoder instr_trap for current dec_instr; ignored when dec_valid=0.
- trap_clear  in  NUM_HARTS  bit h: return hart h from TRAPPED to RUN.
- hart_trapped  out  NUM_HARTS  registered per-hart TRAPPED flag.
- trap_valid  out  1  one-cycle pulse: a trap was captured.
- trap_hart_id  out  HART_ID_W  hart of the captured trap; held until next trap.

Behaviour:
- Per-hart FSM, 2 states:
  - RUN -> TRAPPED when dec_valid && dec_trap && dec_hart_id==h.
  - TRAPPED -> RUN when trap_clear[h].
  - Simultaneous trap and trap_clear for the same hart: trap wins, hart stays or becomes TRAPPED.
- Eligibility: elig[h] = fetch_valid[h] & ~stall_req[h] & state[h]==RUN & ~(dec_valid && dec_hart_id==h).
  - The last term blocks the hart currently in decode, so its trap is resolved before it issues again.
  - A lone eligible hart therefore issues at most every other cycle.
- Arbitration:
  - Scan from (last_grant+1) mod NUM_HARTS upward with wrap; the first eligible hart wins.
  - fetch_ready = one-hot of the winner; all zero if no hart is eligible.
  - last_grant updates only on a grant.
- Issue latency is 1 cycle. On the grant edge:
  - dec_instr <= winner's fetch_instr, dec_hart_id <= winner, dec_valid <= 1.
  - With no grant: dec_valid <= 0, dec_instr <= 32'h0000_0013 (NOP), dec_hart_id holds.
- Trap capture, on the edge where dec_valid && dec_trap:
  - trap_valid <= 1 for one cycle, trap_hart_id <= dec_hart_id.
  - Otherwise trap_valid <= 0.
- dec_trap is combinational from dec_instr through the decoder ROM. It is sampled only at the clock edge, with no extra registering.
- Reset values:
  - dec_valid=0, dec_instr=32'h0000_0013, dec_hart_id=0.
  - trap_valid=0, trap_hart_id=0, hart_trapped=0, all FSMs RUN.
  - last_grant=NUM_HARTS-1, so hart 0 has first priority.
- fetch_ready is all zero while rst=1.
- Reset mid-operation: an in-flight decode instruction is discarded; its trap is not reported.
- fetch_valid deasserting without a grant is legal; the scheduler makes no hold assumption on the fetch side.
- All harts TRAPPED or stalled: no grants, dec_valid=0, pointer frozen.

Optional Feature:
- Macro: HART_SCHED_PERF_EN.
- Defined: adds output perf_issue_cnt (NUM_HARTS*32), with per-hart 32-bit counters incremented on each grant to that hart.
- Defined: adds output perf_idle_cnt (32), incremented on every cycle with no grant.
- Counters wrap modulo 2^32 and are zeroed by rst.
- Undefined: both ports and all counters are absent; function is otherwise identical.

Test Plan:
- Reset, then fetch_valid=8'hFF held, no stalls, no traps -> grants in order h0,h1,...,h7,h0; dec_valid=1 every cycle from cycle 1; dec_instr matches the granted hart's word.
- fetch_valid=8'h04 only -> hart 2 granted on alternate cycles (blocked while in decode); dec_valid toggles 1,0,1,0.
- Hart 3 issues 32'hFFFF_FFFF so the decoder flags trap -> next cycle trap_valid=1, trap_hart_id=3, hart_trapped=8'h08; hart 3 is never granted again despite fetch_valid[3]=1.
- trap_clear[3] pulsed in the same cycle as a new hart-3 trap -> hart_trapped[3] stays 1; a later lone trap_clear[3] -> hart_trapped[3]=0 and hart 3 is granted within NUM_HARTS cycles.
- stall_req=8'h0F with fetch_valid=8'hFF -> only harts 4..7 granted, rotating; release the stall -> rotation continues from last_grant+1.
- rst asserted mid-stream with a trapping instruction in decode -> no trap_valid; all outputs at reset values on the next cycle; hart 0 granted first after release.
- HART_SCHED_PERF_EN: 100 cycles with fetch_valid=8'h01 -> perf_issue_cnt[0]=50, perf_idle_cnt=50.
